// File: rtl/wb_tile_bus_pkg.sv
// wb_tile_bus_pkg: shared types, default tile slave map and address decode helper
// for the tile Wishbone arbiter.
package wb_tile_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR} arb_state_t;

    localparam int MAX_SLAVES = 16;
    localparam int MAX_AW     = 64;

    localparam int SLAVE_DM   = 0;
    localparam int SLAVE_PGAS = 1;
    localparam int SLAVE_NA   = 2;
    localparam int SLAVE_BOOT = 3;

    localparam logic [31:0] DM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DM_MASK   = 32'h8000_0000;
    localparam logic [31:0] PGAS_BASE = 32'h8000_0000;
    localparam logic [31:0] PGAS_MASK = 32'hC000_0000;
    localparam logic [31:0] NA_BASE   = 32'hE000_0000;
    localparam logic [31:0] NA_MASK   = 32'hF000_0000;
    localparam logic [31:0] BOOT_BASE = 32'hF000_0000;
    localparam logic [31:0] BOOT_MASK = 32'hF000_0000;

    localparam logic [127:0] DEFAULT_BASE = {BOOT_BASE, NA_BASE, PGAS_BASE, DM_BASE};
    localparam logic [127:0] DEFAULT_MASK = {BOOT_MASK, NA_MASK, PGAS_MASK, DM_MASK};

    typedef struct packed {
        logic                  hit;
        logic [MAX_SLAVES-1:0] sel;
    } dec_t;

    // Lowest matching slave wins; scanning downwards lets the last hit be the lowest index.
    function automatic dec_t addr_decode(
        input logic [MAX_AW-1:0]            adr,
        input logic [MAX_SLAVES*MAX_AW-1:0] base,
        input logic [MAX_SLAVES*MAX_AW-1:0] mask
    );
        dec_t d;
        d = '0;
        for (int s = MAX_SLAVES - 1; s >= 0; s--)
            if ((adr & mask[s*MAX_AW +: MAX_AW]) == base[s*MAX_AW +: MAX_AW]) begin
                d.sel    = '0;
                d.sel[s] = 1'b1;
                d.hit    = 1'b1;
            end
        return d;
    endfunction

endpackage

// File: rtl/wb_tile_bus_arb_rr.sv
// wb_rr_arbiter: round-robin arbiter with a registered one-hot grant; the pointer
// moves past the releasing owner so it can re-win only when nobody else asks.
module wb_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_sys_n,
    input  logic [N-1:0]  req,
    input  logic          load,
    input  logic          rel,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] k;
    logic [N-1:0]  pick;

    always_comb begin
        pick = '0;
        k    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % N);
            if (req[k]) begin
                pick    = '0;
                pick[k] = 1'b1;
            end
        end
        idx = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) idx = PW'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_sys_n) begin
            ptr   <= '0;
            grant <= '0;
        end else if (load) begin
            grant <= pick;
        end else if (rel) begin
            grant <= '0;
            ptr   <= PW'((int'(idx) + 1) % N);
        end
    end

endmodule

// File: rtl/wb_tile_bus_arb.sv
// wb_tile_bus_arb: Wishbone B3 tile interconnect with round-robin arbitration,
// base/mask decode, error on unmapped addresses and a stall watchdog.
module wb_tile_bus_arb
    import wb_tile_bus_pkg::*;
#(
    parameter int NR_MASTERS = 2,
    parameter int NR_SLAVES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NR_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = DEFAULT_BASE,
    parameter logic [NR_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = DEFAULT_MASK,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_sys_n,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [NR_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NR_MASTERS-1:0]             m_cyc_i,
    input  logic [NR_MASTERS-1:0]             m_stb_i,
    input  logic [NR_MASTERS-1:0]             m_we_i,
    input  logic [NR_MASTERS*3-1:0]           m_cti_i,
    input  logic [NR_MASTERS*2-1:0]           m_bte_i,
    output logic [NR_MASTERS*DATA_WIDTH-1:0]  m_dat_o,
    output logic [NR_MASTERS-1:0]             m_ack_o,
    output logic [NR_MASTERS-1:0]             m_err_o,
    output logic [NR_MASTERS-1:0]             m_rty_o,
    output logic [NR_SLAVES*ADDR_WIDTH-1:0]   s_adr_o,
    output logic [NR_SLAVES*DATA_WIDTH-1:0]   s_dat_o,
    output logic [NR_SLAVES*DATA_WIDTH/8-1:0] s_sel_o,
    output logic [NR_SLAVES-1:0]              s_we_o,
    output logic [NR_SLAVES*3-1:0]            s_cti_o,
    output logic [NR_SLAVES*2-1:0]            s_bte_o,
    output logic [NR_SLAVES-1:0]              s_cyc_o,
    output logic [NR_SLAVES-1:0]              s_stb_o,
    input  logic [NR_SLAVES*DATA_WIDTH-1:0]   s_dat_i,
    input  logic [NR_SLAVES-1:0]              s_ack_i,
    input  logic [NR_SLAVES-1:0]              s_err_i,
    input  logic [NR_SLAVES-1:0]              s_rty_i,
    output logic [NR_MASTERS-1:0]             grant_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = NR_MASTERS > 1 ? $clog2(NR_MASTERS) : 1;

    arb_state_t                    state;
    logic [NR_MASTERS-1:0]         grant, err_q;
    logic [GW-1:0]                 g;
    logic [31:0]                   cnt;
    logic                          load, rel, act, live, stall, unmapped, tmo;
    logic [ADDR_WIDTH-1:0]         adr;
    logic [DATA_WIDTH-1:0]         rdat;
    logic                          cyc, stb;
    logic [MAX_SLAVES*MAX_AW-1:0]  base_x, mask_x;
    logic [MAX_SLAVES-1:0]         ack_x, err_x, rty_x;
    logic [MAX_SLAVES*DATA_WIDTH-1:0] dat_x;
    logic [3:0]                    si;
    logic [NR_SLAVES-1:0]          sel_s;
    dec_t                          dec;

    wb_rr_arbiter #(.N(NR_MASTERS), .PW(GW)) u_arb (
        .clk       (clk),
        .rst_sys_n (rst_sys_n),
        .req       (m_cyc_i),
        .load      (load),
        .rel       (rel),
        .grant     (grant),
        .idx       (g)
    );

    // Unused decode slots get an unmatchable entry (mask 0, base all ones).
    always_comb begin
        base_x = '1;
        mask_x = '0;
        for (int s = 0; s < NR_SLAVES; s++) begin
            base_x[s*MAX_AW +: MAX_AW] = MAX_AW'(SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH]);
            mask_x[s*MAX_AW +: MAX_AW] = MAX_AW'(SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        si = '0;
        for (int s = 0; s < MAX_SLAVES; s++)
            if (dec.sel[s]) si = 4'(s);
    end

    assign adr   = m_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign cyc   = m_cyc_i[g];
    assign stb   = m_stb_i[g];
    assign dec   = addr_decode(MAX_AW'(adr), base_x, mask_x);
    assign ack_x = MAX_SLAVES'(s_ack_i);
    assign err_x = MAX_SLAVES'(s_err_i);
    assign rty_x = MAX_SLAVES'(s_rty_i);
    assign dat_x = (MAX_SLAVES*DATA_WIDTH)'(s_dat_i);
    assign rdat  = dec.hit ? dat_x[si*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign act      = state == ACTIVE;
    assign live     = act && stb && dec.hit;
    assign stall    = live && !(ack_x[si] || err_x[si] || rty_x[si]);
    assign unmapped = act && stb && !dec.hit;
    assign tmo      = TIMEOUT_CYCLES != 0 && stall && cnt == 32'(TIMEOUT_CYCLES - 1);
    assign load     = state == IDLE && |m_cyc_i;
    assign rel      = state != IDLE && !cyc;

    assign sel_s   = act ? dec.sel[NR_SLAVES-1:0] : '0;
    assign s_cyc_o = sel_s & {NR_SLAVES{cyc}};
    assign s_stb_o = sel_s & {NR_SLAVES{stb}};
    assign s_adr_o = {NR_SLAVES{adr}};
    assign s_dat_o = {NR_SLAVES{m_dat_i[g*DATA_WIDTH +: DATA_WIDTH]}};
    assign s_sel_o = {NR_SLAVES{m_sel_i[g*SW +: SW]}};
    assign s_we_o  = {NR_SLAVES{m_we_i[g]}};
    assign s_cti_o = {NR_SLAVES{m_cti_i[g*3 +: 3]}};
    assign s_bte_o = {NR_SLAVES{m_bte_i[g*2 +: 2]}};

    // err from the slave beats a simultaneous ack or rty.
    assign m_ack_o = grant & {NR_MASTERS{live && ack_x[si] && !err_x[si]}};
    assign m_rty_o = grant & {NR_MASTERS{live && rty_x[si] && !err_x[si]}};
    assign m_err_o = (grant & {NR_MASTERS{live && err_x[si]}}) | err_q;
    assign m_dat_o = {NR_MASTERS{rdat}};
    assign grant_o = grant;

    always_ff @(posedge clk) begin
        if (!rst_sys_n) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= '0;
        end else begin
            cnt   <= stall ? cnt + 32'd1 : '0;
            err_q <= '0;
            case (state)
                IDLE:   state <= load ? ACTIVE : IDLE;
                ACTIVE: begin
                    if (!cyc) state <= IDLE;
                    else if (unmapped || tmo) begin
                        state <= ERR;
                        err_q <= grant;
                    end
                end
                default: state <= cyc ? ACTIVE : IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_tile_bus_arb.sv
// tb_wb_tile_bus_arb: directed scenarios then randomized transactions checked against
// a range-based address map and round-robin ownership model.
module tb_wb_tile_bus_arb;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_sys_n;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*3-1:0]  m_cti;
    logic [NM*2-1:0]  m_bte;
    logic [NM*DW-1:0] m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant;
    logic [NS*AW-1:0] s_adr_o;
    logic [NS*DW-1:0] s_dat_o;
    logic [NS*4-1:0]  s_sel_o;
    logic [NS-1:0]    s_we_o, s_cyc_o, s_stb_o;
    logic [NS*3-1:0]  s_cti_o;
    logic [NS*2-1:0]  s_bte_o;
    logic [NS*DW-1:0] s_dat;
    logic [NS-1:0]    s_ack, s_err, s_rty;

    int checks = 0;
    int errors = 0;

    wb_tile_bus_arb #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_sys_n(rst_sys_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_cyc_i(m_cyc),
        .m_stb_i(m_stb), .m_we_i(m_we), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic master(input int m, input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_we[m]  = we;
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = dat;
        m_cti[m*3 +: 3]   = cti;
    endtask

    task automatic slave(input int s, input logic ack, input logic err, input logic [31:0] dat);
        s_ack[s] = ack;
        s_err[s] = err;
        s_dat[s*DW +: DW] = dat;
    endtask

    task automatic idle_all();
        m_adr = '0; m_dat = '0; m_sel = '1; m_cyc = '0; m_stb = '0; m_we = '0;
        m_cti = '0; m_bte = '0;
        s_dat = '0; s_ack = '0; s_err = '0; s_rty = '0;
    endtask

    // Tile address map expressed as address ranges.
    function automatic int ref_slave(input logic [31:0] a);
        if (a < 32'h8000_0000) return 0;
        if (a < 32'hC000_0000) return 1;
        if (a >= 32'hF000_0000) return 3;
        if (a >= 32'hE000_0000) return 2;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [1:0] req, input int p);
        for (int i = 0; i < NM; i++)
            if (req[(p + i) % NM]) return (p + i) % NM;
        return -1;
    endfunction

    initial begin
        int w, sl, waits, rr;
        logic [1:0]  req;
        logic [31:0] a [NM];
        logic [31:0] d;
        logic        dual;

        idle_all();
        rst_sys_n = 1'b0;
        tick(); tick(); settle();
        chk("rst_grant", 64'(grant), 0);
        chk("rst_s_cyc", 64'(s_cyc_o), 0);
        chk("rst_m_ack", 64'(m_ack_o), 0);

        // single master read of DM with two wait states
        rst_sys_n = 1'b1;
        master(0, 1, 1, 0, 32'h0000_0010, 0, 3'b000);
        settle();
        chk("t1_idle_grant", 64'(grant), 0);
        chk("t1_idle_stb", 64'(s_stb_o), 0);
        tick(); settle();
        chk("t1_grant", 64'(grant), 2'b01);
        chk("t1_stb", 64'(s_stb_o), 4'b0001);
        chk("t1_wait_ack", 64'(m_ack_o), 0);
        tick(); settle();
        chk("t1_stb_w2", 64'(s_stb_o), 4'b0001);
        tick(); slave(0, 1, 0, 32'hDEAD_BEEF); settle();
        chk("t1_ack", 64'(m_ack_o), 2'b01);
        chk("t1_dat", 64'(m_dat_o[31:0]), 32'hDEAD_BEEF);
        tick(); slave(0, 0, 0, 0); master(0, 0, 0, 0, 0, 0, 0); settle();
        tick(); settle();
        chk("t1_release", 64'(grant), 0);

        // simultaneous requests after reset
        rst_sys_n = 1'b0;
        tick(); rst_sys_n = 1'b1;
        master(0, 1, 1, 0, 32'h0000_0100, 0, 0);
        master(1, 1, 1, 1, 32'h0000_0200, 32'h55, 0);
        settle();
        tick(); slave(0, 1, 0, 32'h1111); settle();
        chk("t2_grant_m0", 64'(grant), 2'b01);
        chk("t2_adr_m0", 64'(s_adr_o[31:0]), 32'h100);
        chk("t2_ack_m0", 64'(m_ack_o), 2'b01);
        tick(); slave(0, 0, 0, 0); master(0, 0, 0, 0, 0, 0, 0); settle();
        chk("t2_hold_m0", 64'(grant), 2'b01);
        tick(); settle();
        chk("t2_turnaround", 64'(grant), 0);
        tick(); slave(0, 1, 0, 32'h2222); settle();
        chk("t2_grant_m1", 64'(grant), 2'b10);
        chk("t2_adr_m1", 64'(s_adr_o[31:0]), 32'h200);
        chk("t2_we_m1", 64'(s_we_o[0]), 1);
        chk("t2_dat_m1", 64'(s_dat_o[31:0]), 32'h55);
        chk("t2_ack_m1", 64'(m_ack_o), 2'b10);
        tick(); slave(0, 0, 0, 0); master(1, 0, 0, 0, 0, 0, 0); settle();
        tick(); settle();
        chk("t2_idle", 64'(grant), 0);

        // unmapped write by M1
        master(1, 1, 1, 1, 32'hC000_0000, 32'h77, 0);
        tick(); settle();
        chk("t3_grant", 64'(grant), 2'b10);
        chk("t3_no_stb", 64'(s_stb_o), 0);
        chk("t3_no_err_yet", 64'(m_err_o), 0);
        tick(); master(1, 1, 0, 1, 32'hC000_0000, 32'h77, 0); settle();
        chk("t3_err", 64'(m_err_o), 2'b10);
        chk("t3_err_stb", 64'(s_stb_o), 0);
        tick(); settle();
        chk("t3_err_pulse", 64'(m_err_o), 0);
        chk("t3_back_active", 64'(grant), 2'b10);
        master(1, 0, 0, 0, 0, 0, 0);
        tick(); settle();
        chk("t3_idle", 64'(grant), 0);

        // watchdog on a silent NA slave
        master(0, 1, 1, 0, 32'hE000_0004, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick(); settle();
            chk("t4_stall_stb", 64'(s_stb_o), 4'b0100);
            chk("t4_stall_no_err", 64'(m_err_o), 0);
        end
        tick(); settle();
        chk("t4_err", 64'(m_err_o), 2'b01);
        chk("t4_err_stb", 64'(s_stb_o), 0);
        master(0, 1, 0, 0, 32'hE000_0004, 0, 0);
        tick(); settle();
        chk("t4_err_pulse", 64'(m_err_o), 0);
        master(0, 0, 0, 0, 0, 0, 0);
        tick(); settle();

        // 4-beat incrementing burst to BOOT with M1 contending
        master(0, 1, 1, 0, 32'hF000_0000, 0, 3'b010);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            master(0, 1, 1, 0, 32'hF000_0000 + 32'(4 * b), 0, b == 3 ? 3'b111 : 3'b010);
            master(1, 1, 1, 0, 32'h0000_0300, 0, 0);
            slave(3, 1, 0, 32'hA0 + 32'(b));
            settle();
            chk("t5_grant", 64'(grant), 2'b01);
            chk("t5_stb", 64'(s_stb_o), 4'b1000);
            chk("t5_ack", 64'(m_ack_o), 2'b01);
            chk("t5_dat", 64'(m_dat_o[63:32]), 32'hA0 + 32'(b));
            chk("t5_cti", 64'(s_cti_o[2:0]), b == 3 ? 3'b111 : 3'b010);
        end
        tick(); master(0, 0, 0, 0, 0, 0, 0); slave(3, 0, 0, 0); settle();
        chk("t5_hold", 64'(grant), 2'b01);
        tick(); settle();
        chk("t5_turnaround", 64'(grant), 0);
        tick(); settle();
        chk("t5_m1_grant", 64'(grant), 2'b10);
        chk("t5_m1_stb", 64'(s_stb_o), 4'b0001);
        master(1, 0, 0, 0, 0, 0, 0);
        tick(); tick(); settle();

        // reset in the middle of a burst
        master(0, 1, 1, 0, 32'hF000_0000, 0, 3'b010);
        tick(); slave(3, 1, 0, 32'h1234); settle();
        chk("t6_ack", 64'(m_ack_o), 2'b01);
        rst_sys_n = 1'b0;
        tick(); settle();
        chk("t6_rst_grant", 64'(grant), 0);
        chk("t6_rst_cyc", 64'(s_cyc_o), 0);
        chk("t6_rst_ack", 64'(m_ack_o), 0);
        rst_sys_n = 1'b1;
        master(0, 0, 0, 0, 0, 0, 0);
        tick(); settle();
        chk("t6_post_ack", 64'(m_ack_o), 0);
        chk("t6_post_grant", 64'(grant), 0);
        slave(3, 0, 0, 0);

        // randomized transactions
        rr = 0;
        for (int it = 0; it < 40; it++) begin
            req = 2'($urandom_range(1, 3));
            for (int m = 0; m < NM; m++) begin
                a[m] = {4'($urandom_range(0, 15)), 28'($urandom) & 28'hFFF_FFFC};
                if (req[m]) master(m, 1, 1, 1'($urandom), a[m], $urandom, 0);
            end
            w  = rr_pick(req, rr);
            sl = ref_slave(a[w]);
            tick(); settle();
            chk("rnd_grant", 64'(grant), 64'(1) << w);
            if (sl < 0) begin
                chk("rnd_unmapped_stb", 64'(s_stb_o), 0);
                tick(); m_stb[w] = 1'b0; settle();
                chk("rnd_unmapped_err", 64'(m_err_o), 64'(1) << w);
                tick(); settle();
                chk("rnd_err_pulse", 64'(m_err_o), 0);
            end else begin
                waits = $urandom_range(0, 3);
                for (int k = 0; k < waits; k++) begin
                    chk("rnd_wait_stb", 64'(s_stb_o), 64'(1) << sl);
                    chk("rnd_wait_ack", 64'(m_ack_o), 0);
                    tick(); settle();
                end
                dual = ($urandom_range(0, 3) == 0);
                d = $urandom;
                slave(sl, 1, dual, d);
                settle();
                chk("rnd_stb", 64'(s_stb_o), 64'(1) << sl);
                chk("rnd_adr", 64'(s_adr_o[sl*AW +: AW]), a[w]);
                if (dual) begin
                    chk("rnd_dual_err", 64'(m_err_o), 64'(1) << w);
                    chk("rnd_dual_ack", 64'(m_ack_o), 0);
                end else begin
                    chk("rnd_ack", 64'(m_ack_o), 64'(1) << w);
                    chk("rnd_dat", 64'(m_dat_o[w*DW +: DW]), d);
                end
            end
            tick();
            s_ack = '0; s_err = '0;
            for (int m = 0; m < NM; m++) master(m, 0, 0, 0, 0, 0, 0);
            settle();
            tick(); settle();
            chk("rnd_idle", 64'(grant), 0);
            rr = (w + 1) % NM;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_tile_bus_arb.md
Name: wb_tile_bus_arb

Overview:
- Parametrised Wishbone B3 interconnect for a compute tile: NR_MASTERS masters (core I/D ports, NA DMA master) share NR_SLAVES slaves (DM, PGAS, NA, BOOT, ext).
- Provides round-robin arbitration, base/mask address decode, error response on unmapped addresses, and a per-access timeout watchdog.
- Replaces the fixed single-master point-to-point wiring between core and network adapter.

Parameters:
- NR_MASTERS, 2, number of masters (1..8).
- NR_SLAVES, 4, number of slaves (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8); SEL width = DATA_WIDTH/8.
- SLAVE_BASE, {0xF000_0000, 0xE000_0000, 0x8000_0000, 0x0000_0000}, flat NR_SLAVES*ADDR_WIDTH base vector, slave 0 in the LSBs.
- SLAVE_MASK, {0xF000_0000, 0xF000_0000, 0xC000_0000, 0x8000_0000}, flat decode masks.
- TIMEOUT_CYCLES, 255, wait cycles before forced err (0 disables the watchdog).

Ports:
- clk  in  1  tile clock.
- rst_sys_n  in  1  synchronous active-low reset.
- m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i  in  NR_MASTERS × (ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, 1, 1, 1, 3, 2), flat  master requests.
- m_dat_o  out  NR_MASTERS*DATA_WIDTH  read data (shared bus, same value to all).
- m_ack_o, m_err_o, m_rty_o  out  NR_MASTERS each  per-master responses.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  out  NR_SLAVES × respective widths, flat  broadcast request fields.
- s_cyc_o, s_stb_o  out  NR_SLAVES each  per-slave select.
- s_dat_i  in  NR_SLAVES*DATA_WIDTH  slave read data.
- s_ack_i, s_err_i, s_rty_i  in  NR_SLAVES each  slave responses.
- grant_o  out  NR_MASTERS  one-hot current grant (debug/trace).

Behaviour:
- Reset (rst_sys_n=0 at a rising clk):
  - State goes to IDLE; RR pointer = 0; timeout counter = 0; grant_o = 0.
  - All s_cyc_o/s_stb_o and m_ack_o/m_err_o/m_rty_o are 0 in the following cycle.
  - Reset mid-transfer abandons the transfer and generates no response.
- FSM states: IDLE, ACTIVE, ERR.
- IDLE:
  - If any m_cyc_i is high, select the first requester at or after the RR pointer (wrap modulo NR_MASTERS), register its grant and go to ACTIVE.
  - Grant appears 1 cycle after the request; no slave access happens in IDLE.
- ACTIVE:
  - Request fields of the granted master are forwarded combinationally to every slave.
  - Decoded slave: lowest s with (adr & MASK[s]) == BASE[s].
  - s_cyc_o[s] = m_cyc_i[g]; s_stb_o[s] = m_stb_i[g]; all other slaves get 0.
  - Responses of the decoded slave pass combinationally to the granted master only; m_dat_o = s_dat_i of the decoded slave.
  - Grant is held while m_cyc_i[g] = 1, including bursts and locked sequences.
- Unmapped address: when stb is high and no slave matches, drive no slave and go to ERR.
- Timeout:
  - Counter increments each cycle stb is high without ack/err/rty from the decoded slave; it clears on any response or when stb is low.
  - When the counter reaches TIMEOUT_CYCLES, go to ERR; the slave's cyc/stb are forced to 0 during ERR.
- ERR:
  - Assert m_err_o[g] for exactly 1 cycle (registered); all slave strobes are 0.
  - Return to ACTIVE if m_cyc_i[g] is still high, else go to IDLE.
- Release:
  - When m_cyc_i[g] drops in ACTIVE, go to IDLE in the next cycle and set RR pointer = g+1 (wrap).
  - The same master may re-win only if no other master is requesting.
  - Release in the same cycle as an ack is legal; the ack is delivered.
- Latency: grant 1 cycle; data phase 0 added cycles; bus turnaround 1 idle cycle between owners.
- Dual slave response (ack and err in the same cycle): err takes precedence, ack is suppressed.
- A response arriving while stb is low is ignored.

Decomposition:
- Package wb_tile_bus_pkg holds:
  - arb_state_t enum (IDLE/ACTIVE/ERR);
  - default slave map constants SLAVE_DM/PGAS/NA/BOOT indices, bases and masks;
  - function addr_decode(adr, base, mask) returning a one-hot vector plus a hit bit.
- Sub-module wb_rr_arbiter: parametrised round-robin arbiter (req, pointer update on release, one-hot grant).

Test Plan:
- Single master M0 reads 0x0000_0010, DM acks with 0xDEADBEEF after 2 waits → s_stb_o[0]=1 only, m_ack_o[0]=1 with m_dat_o=0xDEADBEEF, grant_o=01 from cycle 1.
- M0 and M1 raise cyc in the same cycle after reset → M0 granted first; on M0 release, 1 idle cycle, then M1 granted (grant_o=10); pointer then = 0.
- M1 writes 0xC000_0000 (unmapped) → no s_stb_o high, m_err_o[1] pulses for exactly 1 cycle, FSM returns to ACTIVE.
- M0 accesses NA at 0xE000_0004 and the slave never acks, TIMEOUT_CYCLES=8 → err after 8 stalled cycles, s_stb_o[2]=0 during ERR.
- 4-beat incrementing burst (cti=010…111) to BOOT at 0xF000_0000 while M1 requests → M0 keeps the grant across all 4 acks; M1 is granted only after M0 drops cyc.
- rst_sys_n pulled low mid-burst → next cycle all s_cyc_o/m_ack_o=0, grant_o=0, no spurious ack after reset release.
